// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;
    localparam logic [31:0] PC_START_DEFAULT = 32'h00400020;
    localparam int          INSN_BYTES       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, insn} entries; the head is visible combinationally.
// Flush wins over push and pop.
module fetch_queue #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero before the first fetch.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Stallable instruction-fetch stage: PC register, IDLE/RUN FSM, one in-flight
// memory read, credit-limited issue into a small queue, redirect with squash.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(PC_START_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_insn,
    output logic [ADDR_W-1:0] out_pc,
    output logic              misalign_err
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              misalign_err_q, misalign_err_d;

    logic                     q_push, q_pop, q_empty, q_full;
    logic [CNT_W-1:0]         q_count;
    logic [ADDR_W+DATA_W-1:0] q_head;
    logic [OCC_W-1:0]         occupancy;
    logic                     issue;

    always_comb begin
        out_valid = !q_empty && !redirect;
        q_pop     = out_valid && out_ready;
        // A pop this cycle frees a slot for the response arriving next cycle,
        // which is what lets a two-entry queue stream one instruction per cycle.
        occupancy = OCC_W'(q_count) + OCC_W'(inflight_q) - OCC_W'(q_pop);
        issue     = (state_q == RUN) && en && !redirect && (occupancy < OCC_W'(DEPTH));
        q_push    = inflight_q && !redirect;

        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pc_d           = issue ? pc_q + ADDR_W'(INSN_BYTES) : pc_q;
        inflight_d     = issue;
        inflight_pc_d  = issue ? pc_q : inflight_pc_q;
        misalign_err_d = misalign_err_q;
        if (redirect) begin
            pc_d           = {redirect_pc[ADDR_W-1:2], 2'b00};
            misalign_err_d = misalign_err_q || (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pc_q           <= PC_START;
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            inflight_q     <= inflight_d;
            inflight_pc_q  <= inflight_pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .wdata ({inflight_pc_q, imem_rdata}),
        .rdata (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    // The issue credit must never let a response land in a full queue.
    assert property (@(posedge clk) disable iff (reset) !(q_full && q_push && !q_pop));

    assign imem_req     = issue;
    assign imem_addr    = pc_q;
    assign out_pc       = q_head[ADDR_W+DATA_W-1:DATA_W];
    assign out_insn     = q_head[DATA_W-1:0];
    assign misalign_err = misalign_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] PC_START = 32'h00400020;
    localparam logic [31:0] MEM_XOR  = 32'hFFFF0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: fetch pointer, run flag, one tagged outstanding read, entry queue.
    logic [31:0] m_pc = PC_START;
    logic [31:0] m_infl_pc = '0;
    bit          m_run = 1'b0;
    bit          m_infl = 1'b0;
    bit          m_err = 1'b0;
    logic [63:0] m_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .PC_START (PC_START)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_insn     (out_insn),
        .out_pc       (out_pc),
        .misalign_err (misalign_err)
    );

    // Synchronous memory: data for a request appears the following cycle, garbage otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ MEM_XOR) : $urandom();
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit rd, input bit rdy,
                        input logic [31:0] rpc);
        bit          m_valid, m_pop, m_req;
        logic [63:0] head;
        @(negedge clk);
        reset       = r;
        en          = e;
        redirect    = rd;
        out_ready   = rdy;
        redirect_pc = rpc;
        #1;
        m_valid = (m_q.size() != 0) && !rd;
        m_pop   = m_valid && rdy;
        m_req   = m_run && e && !rd &&
                  ((m_q.size() - (m_pop ? 1 : 0) + (m_infl ? 1 : 0)) < DEPTH);
        if (!r) begin
            check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_req});
            if (m_req) check_eq("imem_addr", imem_addr, m_pc);
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                head = m_q[0];
                check_eq("out_pc", out_pc, head[63:32]);
                check_eq("out_insn", out_insn, head[31:0]);
            end
            check_eq("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        end
        if (r) begin
            m_pc   = PC_START;
            m_run  = 1'b0;
            m_infl = 1'b0;
            m_err  = 1'b0;
            m_q.delete();
        end else begin
            if (rd) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
                if (rpc[1:0] != 2'b00) m_err = 1'b1;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_infl) m_q.push_back({m_infl_pc, m_infl_pc ^ MEM_XOR});
            end
            m_infl = m_req;
            if (m_req) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
            m_run = e;
        end
    endtask

    initial begin
        bit          r, e, rd, rdy;
        logic [31:0] rpc;

        step(1, 0, 0, 1, '0);
        step(1, 0, 0, 1, '0);
        @(posedge clk);
        #1;
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_out_insn", out_insn, 32'h0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_misalign", {31'd0, misalign_err}, 32'd0);

        repeat (12) step(0, 1, 0, 1, '0);
        repeat (6)  step(0, 1, 0, 0, '0);
        repeat (6)  step(0, 1, 0, 1, '0);

        step(0, 1, 1, 1, 32'h00400100);
        repeat (5) step(0, 1, 0, 1, '0);
        step(0, 1, 1, 1, 32'h00400102);
        repeat (5) step(0, 1, 0, 1, '0);
        step(0, 1, 1, 1, 32'hFFFFFFF8);
        repeat (6) step(0, 1, 0, 1, '0);

        repeat (3) step(0, 1, 0, 0, '0);
        repeat (5) step(0, 0, 0, 1, '0);
        repeat (3) step(0, 1, 0, 1, '0);
        step(0, 0, 0, 1, '0);
        repeat (3) step(0, 0, 0, 1, '0);

        repeat (4) step(0, 1, 0, 1, '0);
        step(1, 1, 1, 1, 32'h00400200);
        repeat (5) step(0, 1, 0, 1, '0);

        repeat (3000) begin
            r   = ($urandom_range(0, 99) == 0);
            e   = ($urandom_range(0, 9) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom())
                                              : 32'h00400000 + (32'($urandom_range(0, 255)) << 2);
            step(r, e, rd, rdy, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
